// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and beat layout for the UDP -> RapidIO width packer.
// Default geometry is 32-bit input words, two words per output beat.
package udp_pkg;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_RATIO     = 2;
  localparam int DEF_LEN_WIDTH = 16;
  localparam int DEF_CNT_WIDTH = 16;

  localparam int OUT_WIDTH = DEF_IN_WIDTH * DEF_RATIO;
  localparam int KEEP_W    = OUT_WIDTH / 8;
  localparam int SLOT_W    = $clog2(DEF_RATIO);

  // Field order matches the flat vector carried through the output stage.
  typedef struct packed {
    logic [OUT_WIDTH-1:0]     data;
    logic [KEEP_W-1:0]        keep;
    logic                     first;
    logic                     last;
    logic [DEF_LEN_WIDTH-1:0] length;
  } beat_t;

  // Bit count of one flattened beat for an arbitrary geometry.
  function automatic int beat_bits(input int in_width, input int ratio, input int len_width);
    return in_width * ratio + (in_width * ratio) / 8 + 2 + len_width;
  endfunction

endpackage

// File: rtl/udp_skid_reg.sv
// udp_skid_reg: single registered valid/ready stage. Accepts a new beat
// whenever it is empty or its current beat is being taken this cycle.
module udp_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on a free slot, otherwise hold the beat until downstream takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/udp_stream_packer.sv
// udp_stream_packer: N:1 width up-converter, UDP receive words into RapidIO
// beats. First word of a beat lands in the most significant lane; partial
// beats are left-aligned. A new first word arriving mid-beat discards the
// partial beat and counts an error.
// Optional: define UDP_PACKER_LEN_CHECK_EN to compare the summed byte enables
// against the captured length and flag mismatches on rapid_len_err_out.
module udp_stream_packer
  import udp_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int RATIO     = DEF_RATIO,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                        clk_udp,
  input  logic                        reset_udp_n,
  input  logic [IN_WIDTH-1:0]         udp_data_in,
  input  logic                        udp_valid_in,
  input  logic                        udp_first_in,
  input  logic                        udp_last_in,
  input  logic [IN_WIDTH/8-1:0]       udp_keep_in,
  input  logic [LEN_WIDTH-1:0]        udp_length_in,
  output logic                        udp_ready_out,
  output logic [IN_WIDTH*RATIO-1:0]   rapid_data_out,
  output logic [IN_WIDTH*RATIO/8-1:0] rapid_keep_out,
  output logic                        rapid_valid_out,
  output logic                        rapid_first_out,
  output logic                        rapid_last_out,
  output logic [LEN_WIDTH-1:0]        rapid_length_out,
  input  logic                        rapid_ready_in,
`ifdef UDP_PACKER_LEN_CHECK_EN
  output logic                        rapid_len_err_out,
`endif
  output logic [CNT_WIDTH-1:0]        pkt_cnt_out,
  output logic [CNT_WIDTH-1:0]        err_cnt_out
);

  localparam int L_OUT_W     = IN_WIDTH * RATIO;
  localparam int L_KEEP_W    = L_OUT_W / 8;
  localparam int L_IN_KEEP_W = IN_WIDTH / 8;
  localparam int L_SLOT_W    = $clog2(RATIO);
`ifdef UDP_PACKER_LEN_CHECK_EN
  localparam int L_BEAT_W    = beat_bits(IN_WIDTH, RATIO, LEN_WIDTH) + 1;
`else
  localparam int L_BEAT_W    = beat_bits(IN_WIDTH, RATIO, LEN_WIDTH);
`endif
  localparam logic [L_SLOT_W-1:0]  SLOT_MAX = L_SLOT_W'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [L_SLOT_W-1:0]  r_slot;
  logic [L_OUT_W-1:0]   r_acc_data;
  logic [L_KEEP_W-1:0]  r_acc_keep;
  logic                 r_acc_first;
  logic [LEN_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  logic                 w_accept;
  logic                 w_err;
  logic                 w_emit;
  logic [L_SLOT_W-1:0]  w_slot_eff;
  logic [L_OUT_W-1:0]   w_data_next;
  logic [L_KEEP_W-1:0]  w_keep_next;
  logic                 w_first_next;
  logic [LEN_WIDTH-1:0] w_len_cur;
  logic [1:0]           w_err_inc;
  logic [L_BEAT_W-1:0]  w_beat;
  logic [L_BEAT_W-1:0]  w_beat_out;

  assign w_accept     = udp_valid_in && udp_ready_out;
  assign w_err        = w_accept && udp_first_in && (r_slot != '0);
  assign w_slot_eff   = w_err ? '0 : r_slot;
  assign w_emit       = w_accept && ((w_slot_eff == SLOT_MAX) || udp_last_in);
  assign w_first_next = (!w_err && r_acc_first) || udp_first_in;
  assign w_len_cur    = (w_accept && udp_first_in) ? udp_length_in : r_len;

  // Merge the incoming word into its lane on top of the (possibly discarded) accumulation.
  always_comb begin
    w_data_next = w_err ? '0 : r_acc_data;
    w_keep_next = w_err ? '0 : r_acc_keep;
    for (int l = 0; l < RATIO; l++) begin
      if (l == RATIO - 1 - int'(w_slot_eff)) begin
        w_data_next[l*IN_WIDTH +: IN_WIDTH]       = udp_data_in;
        w_keep_next[l*L_IN_KEEP_W +: L_IN_KEEP_W] = udp_keep_in;
      end
    end
  end

`ifdef UDP_PACKER_LEN_CHECK_EN
  logic [LEN_WIDTH-1:0] r_byte_cnt;
  logic [LEN_WIDTH-1:0] w_byte_sum;
  logic                 w_len_err;

  // Running byte total of the packet including the current word.
  always_comb begin
    w_byte_sum = udp_first_in ? '0 : r_byte_cnt;
    for (int i = 0; i < L_IN_KEEP_W; i++) begin
      w_byte_sum = w_byte_sum + LEN_WIDTH'(udp_keep_in[i]);
    end
    w_len_err = w_accept && udp_last_in && (w_byte_sum != w_len_cur);
  end

  // Byte accumulator restarts from each first word.
  always_ff @(posedge clk_udp) begin
    if (!reset_udp_n) r_byte_cnt <= '0;
    else if (w_accept) r_byte_cnt <= w_byte_sum;
  end

  assign w_err_inc = {1'b0, w_err} + {1'b0, w_len_err};
  assign w_beat    = {w_data_next, w_keep_next, w_first_next, udp_last_in, w_len_cur, w_len_err};
  assign {rapid_data_out, rapid_keep_out, rapid_first_out, rapid_last_out,
          rapid_length_out, rapid_len_err_out} = w_beat_out;
`else
  assign w_err_inc = {1'b0, w_err};
  assign w_beat    = {w_data_next, w_keep_next, w_first_next, udp_last_in, w_len_cur};
  assign {rapid_data_out, rapid_keep_out, rapid_first_out, rapid_last_out,
          rapid_length_out} = w_beat_out;
`endif

  // Accumulate words; clear the accumulator whenever a beat leaves for the output stage.
  always_ff @(posedge clk_udp) begin
    if (!reset_udp_n) begin
      r_slot      <= '0;
      r_acc_data  <= '0;
      r_acc_keep  <= '0;
      r_acc_first <= 1'b0;
      r_len       <= '0;
    end else if (w_accept) begin
      if (udp_first_in) r_len <= udp_length_in;
      if (w_emit) begin
        r_slot      <= '0;
        r_acc_data  <= '0;
        r_acc_keep  <= '0;
        r_acc_first <= 1'b0;
      end else begin
        r_slot      <= w_slot_eff + L_SLOT_W'(1);
        r_acc_data  <= w_data_next;
        r_acc_keep  <= w_keep_next;
        r_acc_first <= w_first_next;
      end
    end
  end

  // Packet counter wraps; error counter saturates.
  always_ff @(posedge clk_udp) begin
    if (!reset_udp_n) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (rapid_valid_out && rapid_ready_in && rapid_last_out) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_err_inc != 2'd0) begin
        if (r_err_cnt > CNT_MAX - CNT_WIDTH'(w_err_inc)) r_err_cnt <= CNT_MAX;
        else r_err_cnt <= r_err_cnt + CNT_WIDTH'(w_err_inc);
      end
    end
  end

  assign pkt_cnt_out = r_pkt_cnt;
  assign err_cnt_out = r_err_cnt;

  udp_skid_reg #(
    .WIDTH(L_BEAT_W)
  ) u_skid (
    .i_clk  (clk_udp),
    .i_rst_n(reset_udp_n),
    .i_valid(w_emit),
    .i_data (w_beat),
    .o_ready(udp_ready_out),
    .o_valid(rapid_valid_out),
    .o_data (w_beat_out),
    .i_ready(rapid_ready_in)
  );

endmodule
